// File: rtl/mem_port_arbiter_pkg.sv
// memarb_pkg: shared types and constants for the memory port arbiter.
//   owner_e      - which requester a read belongs to (fetch or data port)
//   *_DEF        - default address/data widths of the memory port
//   STARVE_W     - width of the fetch starvation counter
package memarb_pkg;
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;
  localparam int STARVE_W   = 4;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the fetch port, the data port and the memory
// slave port seen by the arbiter.
//   slave  modport - the arbiter's view (takes requests, drives memory)
//   master modport - the surrounding system's view (core ports + memory)
interface mem_port_arbiter_if import memarb_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();
  // fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  // data port
  logic                dm_req;
  logic                dm_we;
  logic [ADDR_W-1:0]   dm_addr;
  logic [DATA_W-1:0]   dm_wdata;
  logic [DATA_W/8-1:0] dm_be;
  logic                dm_gnt;
  logic                dm_rvalid;
  logic [DATA_W-1:0]   dm_rdata;
  // memory slave port
  logic [ADDR_W-1:0]   mem_address;
  logic                mem_clken;
  logic                mem_chipselect;
  logic                mem_write;
  logic [DATA_W-1:0]   mem_writedata;
  logic [DATA_W/8-1:0] mem_byteenable;
  logic [DATA_W-1:0]   mem_readdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be, mem_readdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_address, mem_clken, mem_chipselect, mem_write, mem_writedata, mem_byteenable
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be, mem_readdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_address, mem_clken, mem_chipselect, mem_write, mem_writedata, mem_byteenable
  );
endinterface

// File: rtl/mem_port_arbiter_read_tag_pipe.sv
// read_tag_pipe: delay line of {valid, owner} tags that follows each read
// through the memory so returning data can be steered to its requester.
//   clk, reset           - clock, synchronous active-high clear of all tags
//   in_valid, in_owner   - tag entering at this clock edge
//   out_valid, out_owner - tag leaving after DEPTH edges
module read_tag_pipe import memarb_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   in_valid,
  input  owner_e in_owner,
  output logic   out_valid,
  output owner_e out_owner
);
  logic [DEPTH-1:0] vld_pipe_q, vld_pipe_d;
  logic [DEPTH-1:0] own_pipe_q, own_pipe_d;

  always_comb begin
    vld_pipe_d = {vld_pipe_q[DEPTH-2:0], in_valid};
    own_pipe_d = {own_pipe_q[DEPTH-2:0], logic'(in_owner)};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe_q <= '0;
      own_pipe_q <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      own_pipe_q <= own_pipe_d;
    end
  end

  assign out_valid = vld_pipe_q[DEPTH-1];
  assign out_owner = owner_e'(own_pipe_q[DEPTH-1]);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: merges the core's fetch read port and data read/write
// port onto one fixed-latency memory slave port.
//   clk, reset - clock, synchronous active-high reset
//   bus        - fetch/data request ports and the memory command/readdata
// The data port normally wins; once fetch has been refused STARVE_LIMIT
// cycles in a row it wins instead. The winning request is registered onto
// the memory port; reads carry a tag that emerges with the read data.
module mem_port_arbiter import memarb_pkg::*; #(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int READ_LATENCY = 1,
  parameter int STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);
  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
  logic                cs_q, cs_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] be_q, be_d;
  logic                if_gnt, dm_gnt;
  logic                tag_vld;
  owner_e              tag_own;

  always_comb begin
    dm_gnt = bus.dm_req & ~reset & ~(bus.if_req & (starve_cnt_q == LIMIT));
    if_gnt = bus.if_req & ~reset & ~dm_gnt;

    // counts consecutive refused fetch cycles, saturating at the limit
    starve_cnt_d = starve_cnt_q;
    if (~bus.if_req | if_gnt)     starve_cnt_d = '0;
    else if (starve_cnt_q != LIMIT) starve_cnt_d = starve_cnt_q + 1'b1;

    // address/data/byteenable hold through idle cycles
    cs_d    = dm_gnt | if_gnt;
    we_d    = dm_gnt & bus.dm_we;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    if (dm_gnt) begin
      addr_d  = bus.dm_addr;
      wdata_d = bus.dm_wdata;
      be_d    = bus.dm_we ? bus.dm_be : '1;
    end else if (if_gnt) begin
      addr_d  = bus.if_addr;
      be_d    = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_q <= '0;
      cs_q         <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      cs_q         <= cs_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
    end
  end

  // one stage for the command register plus one per memory latency cycle
  read_tag_pipe #(.DEPTH(1 + READ_LATENCY)) u_tags (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (if_gnt | (dm_gnt & ~bus.dm_we)),
    .in_owner  (dm_gnt ? OWN_DM : OWN_IF),
    .out_valid (tag_vld),
    .out_owner (tag_own)
  );

  assign bus.if_gnt         = if_gnt;
  assign bus.dm_gnt         = dm_gnt;
  assign bus.if_rvalid      = tag_vld & (tag_own == OWN_IF) & ~reset;
  assign bus.dm_rvalid      = tag_vld & (tag_own == OWN_DM) & ~reset;
  assign bus.if_rdata       = bus.mem_readdata;
  assign bus.dm_rdata       = bus.mem_readdata;
  assign bus.mem_clken      = 1'b1;
  assign bus.mem_chipselect = cs_q;
  assign bus.mem_write      = we_q;
  assign bus.mem_address    = addr_q;
  assign bus.mem_writedata  = wdata_q;
  assign bus.mem_byteenable = be_q;
endmodule
